// File: rtl/hwpe_stream_package.sv
// Shared types and constants for the HWPE stream sink blocks.
package hwpe_stream_package;

  typedef enum logic {
    SINK_IDLE    = 1'b0,
    SINK_WORKING = 1'b1
  } sink_strided_state_t;

  localparam int unsigned HWPE_TCDM_WORD_BYTES = 4;

endpackage

// File: rtl/hwpe_stream_strided_addrgen.sv
// Two-level (line/stride) address generator for the strided stream sink.
// Holds the latched transfer configuration and the line/beat counters.
module hwpe_stream_strided_addrgen
  import hwpe_stream_package::*;
#(
  parameter int unsigned TRANS_CNT_W   = 16,
  parameter int unsigned LINE_CNT_W    = 16,
  parameter int unsigned NB_TCDM_PORTS = 2
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   clear_i,
  input  logic                   start_i,
  input  logic                   enable_i,
  input  logic [31:0]            base_addr_i,
  input  logic [TRANS_CNT_W-1:0] trans_size_i,
  input  logic [LINE_CNT_W-1:0]  line_length_i,
  input  logic [31:0]            line_stride_i,
  output logic [31:0]            word_addr_o,
  output logic                   last_beat_o,
  output logic [TRANS_CNT_W-1:0] beat_cnt_o
);

  localparam logic [31:0]            BEAT_BYTES = 32'(HWPE_TCDM_WORD_BYTES * NB_TCDM_PORTS);
  localparam logic [LINE_CNT_W-1:0]  LINE_ONE   = LINE_CNT_W'(1);
  localparam logic [TRANS_CNT_W-1:0] TRANS_ONE  = TRANS_CNT_W'(1);

  logic [TRANS_CNT_W-1:0] trans_size_q;
  logic [LINE_CNT_W-1:0]  line_length_q;
  logic [31:0]            line_stride_q;
  logic [31:0]            line_base_q;
  logic [31:0]            word_addr_q;
  logic [LINE_CNT_W-1:0]  line_cnt_q;
  logic [TRANS_CNT_W-1:0] beat_cnt_q;

  // Latch configuration on start, then advance line/word addresses on every accepted beat.
  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      trans_size_q  <= '0;
      line_length_q <= '0;
      line_stride_q <= '0;
      line_base_q   <= '0;
      word_addr_q   <= '0;
      line_cnt_q    <= '0;
      beat_cnt_q    <= '0;
    end else if (clear_i) begin
      trans_size_q  <= '0;
      line_length_q <= '0;
      line_stride_q <= '0;
      line_base_q   <= '0;
      word_addr_q   <= '0;
      line_cnt_q    <= '0;
      beat_cnt_q    <= '0;
    end else if (start_i) begin
      trans_size_q  <= trans_size_i;
      // A zero line length would never close a line; treat it as one beat per line.
      line_length_q <= (line_length_i == '0) ? LINE_ONE : line_length_i;
      line_stride_q <= line_stride_i;
      line_base_q   <= base_addr_i;
      word_addr_q   <= base_addr_i;
      line_cnt_q    <= '0;
      beat_cnt_q    <= '0;
    end else if (enable_i) begin
      if (line_cnt_q == line_length_q - LINE_ONE) begin
        line_base_q <= line_base_q + line_stride_q;
        word_addr_q <= line_base_q + line_stride_q;
        line_cnt_q  <= '0;
      end else begin
        word_addr_q <= word_addr_q + BEAT_BYTES;
        line_cnt_q  <= line_cnt_q + LINE_ONE;
      end
      beat_cnt_q <= beat_cnt_q + TRANS_ONE;
    end
  end

  assign word_addr_o = word_addr_q;
  assign last_beat_o = (beat_cnt_q == trans_size_q - TRANS_ONE);
  assign beat_cnt_o  = beat_cnt_q;

endmodule

// File: rtl/hwpe_stream_sink_strided.sv
// Multi-port strided store sink: splits each stream beat into 32-bit TCDM
// write requests, one per port, each port handshaking independently.
module hwpe_stream_sink_strided
  import hwpe_stream_package::*;
#(
  parameter int unsigned DATA_WIDTH    = 64,
  parameter int unsigned NB_TCDM_PORTS = DATA_WIDTH / 32,
  parameter int unsigned TRANS_CNT_W   = 16,
  parameter int unsigned LINE_CNT_W    = 16
) (
  input  logic                        clk_i,
  input  logic                        rst_ni,
  input  logic                        clear_i,
  input  logic                        req_start_i,
  input  logic [31:0]                 base_addr_i,
  input  logic [TRANS_CNT_W-1:0]      trans_size_i,
  input  logic [LINE_CNT_W-1:0]       line_length_i,
  input  logic [31:0]                 line_stride_i,
  input  logic [DATA_WIDTH-1:0]       stream_data_i,
  input  logic [DATA_WIDTH/8-1:0]     stream_strb_i,
  input  logic                        stream_valid_i,
  output logic                        stream_ready_o,
  output logic [NB_TCDM_PORTS-1:0]    tcdm_req_o,
  input  logic [NB_TCDM_PORTS-1:0]    tcdm_gnt_i,
  output logic [32*NB_TCDM_PORTS-1:0] tcdm_add_o,
  output logic [NB_TCDM_PORTS-1:0]    tcdm_wen_o,
  output logic [4*NB_TCDM_PORTS-1:0]  tcdm_be_o,
  output logic [32*NB_TCDM_PORTS-1:0] tcdm_data_o,
  output logic                        ready_start_o,
  output logic                        in_progress_o,
  output logic                        done_o,
  output logic [TRANS_CNT_W-1:0]      beat_cnt_o
);

  sink_strided_state_t state_q, state_d;

  logic [NB_TCDM_PORTS-1:0] sent_q;
  logic [NB_TCDM_PORTS-1:0] active;
  logic [NB_TCDM_PORTS-1:0] port_done;
  logic [NB_TCDM_PORTS-1:0] req;
  logic                     working;
  logic                     accept;
  logic                     start_latch;
  logic                     trans_zero;
  logic                     done_d;
  logic                     done_q;
  logic                     last_beat;
  logic [31:0]              word_addr;

  assign working     = (state_q == SINK_WORKING);
  assign trans_zero  = (trans_size_i == '0);
  assign start_latch = (state_q == SINK_IDLE) && req_start_i && !clear_i;

  hwpe_stream_strided_addrgen #(
    .TRANS_CNT_W   (TRANS_CNT_W),
    .LINE_CNT_W    (LINE_CNT_W),
    .NB_TCDM_PORTS (NB_TCDM_PORTS)
  ) i_addrgen (
    .clk_i         (clk_i),
    .rst_ni        (rst_ni),
    .clear_i       (clear_i),
    .start_i       (start_latch),
    .enable_i      (accept),
    .base_addr_i   (base_addr_i),
    .trans_size_i  (trans_size_i),
    .line_length_i (line_length_i),
    .line_stride_i (line_stride_i),
    .word_addr_o   (word_addr),
    .last_beat_o   (last_beat),
    .beat_cnt_o    (beat_cnt_o)
  );

  // Per-port request generation and TCDM output muxing; everything is zero outside WORKING.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path can infer a latch.
    active      = '0;
    req         = '0;
    port_done   = '0;
    tcdm_add_o  = '0;
    tcdm_be_o   = '0;
    tcdm_data_o = '0;
    for (int ii = 0; ii < int'(NB_TCDM_PORTS); ii++) begin
      active[ii]    = |stream_strb_i[ii*4 +: 4];
      req[ii]       = working && stream_valid_i && active[ii] && !sent_q[ii];
      port_done[ii] = !active[ii] || sent_q[ii] || tcdm_gnt_i[ii];
      if (working) begin
        tcdm_add_o[ii*32 +: 32]  = word_addr + 32'(ii * int'(HWPE_TCDM_WORD_BYTES));
        tcdm_be_o[ii*4 +: 4]     = stream_strb_i[ii*4 +: 4];
        tcdm_data_o[ii*32 +: 32] = stream_data_i[ii*32 +: 32];
      end
    end
  end

  assign accept         = working && stream_valid_i && (&port_done);
  assign stream_ready_o = accept;
  assign tcdm_req_o     = req;
  assign tcdm_wen_o     = '0;

  // Next-state logic: clear overrides start and any beat completion.
  always_comb begin
    state_d = state_q;
    done_d  = 1'b0;
    case (state_q)
      SINK_IDLE: begin
        if (req_start_i) begin
          if (trans_zero) done_d  = 1'b1;
          else            state_d = SINK_WORKING;
        end
      end
      SINK_WORKING: begin
        if (accept && last_beat) begin
          state_d = SINK_IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = SINK_IDLE;
    endcase
    if (clear_i) begin
      state_d = SINK_IDLE;
      done_d  = 1'b0;
    end
  end

  // State and done-pulse registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= SINK_IDLE;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      done_q  <= done_d;
    end
  end

  // Per-port sent flags: set on grant, cleared when the whole beat is accepted.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sent_q <= '0;
    end else if (clear_i || accept) begin
      sent_q <= '0;
    end else begin
      sent_q <= sent_q | (req & tcdm_gnt_i);
    end
  end

  assign ready_start_o = (state_q == SINK_IDLE);
  assign in_progress_o = working;
  assign done_o        = done_q;

endmodule

// File: tb/tb_hwpe_stream_sink_strided.sv
// Scoreboard bench for hwpe_stream_sink_strided (64-bit stream, 2 TCDM ports).
// Expected TCDM writes are queued by the stimulus; a negedge monitor pops and
// compares them whenever a port handshakes.
module tb_hwpe_stream_sink_strided;

  localparam int DW = 64;
  localparam int NP = 2;

  typedef struct {
    int          port;
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  be;
  } wr_t;

  logic              clk_i = 1'b0;
  logic              rst_ni = 1'b0;
  logic              clear_i = 1'b0;
  logic              req_start_i = 1'b0;
  logic [31:0]       base_addr_i = '0;
  logic [15:0]       trans_size_i = '0;
  logic [15:0]       line_length_i = '0;
  logic [31:0]       line_stride_i = '0;
  logic [DW-1:0]     stream_data_i = '0;
  logic [DW/8-1:0]   stream_strb_i = '0;
  logic              stream_valid_i = 1'b0;
  logic              stream_ready_o;
  logic [NP-1:0]     tcdm_req_o;
  logic [NP-1:0]     tcdm_gnt_i = '1;
  logic [32*NP-1:0]  tcdm_add_o;
  logic [NP-1:0]     tcdm_wen_o;
  logic [4*NP-1:0]   tcdm_be_o;
  logic [32*NP-1:0]  tcdm_data_o;
  logic              ready_start_o;
  logic              in_progress_o;
  logic              done_o;
  logic [15:0]       beat_cnt_o;

  int  n_vec = 0;
  int  n_err = 0;
  wr_t exp_q[$];

  always #5 clk_i = ~clk_i;

  hwpe_stream_sink_strided #(
    .DATA_WIDTH    (DW),
    .NB_TCDM_PORTS (NP),
    .TRANS_CNT_W   (16),
    .LINE_CNT_W    (16)
  ) dut (
    .clk_i          (clk_i),
    .rst_ni         (rst_ni),
    .clear_i        (clear_i),
    .req_start_i    (req_start_i),
    .base_addr_i    (base_addr_i),
    .trans_size_i   (trans_size_i),
    .line_length_i  (line_length_i),
    .line_stride_i  (line_stride_i),
    .stream_data_i  (stream_data_i),
    .stream_strb_i  (stream_strb_i),
    .stream_valid_i (stream_valid_i),
    .stream_ready_o (stream_ready_o),
    .tcdm_req_o     (tcdm_req_o),
    .tcdm_gnt_i     (tcdm_gnt_i),
    .tcdm_add_o     (tcdm_add_o),
    .tcdm_wen_o     (tcdm_wen_o),
    .tcdm_be_o      (tcdm_be_o),
    .tcdm_data_o    (tcdm_data_o),
    .ready_start_o  (ready_start_o),
    .in_progress_o  (in_progress_o),
    .done_o         (done_o),
    .beat_cnt_o     (beat_cnt_o)
  );

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Queue the expected per-port writes of one beat at a hand-computed word address.
  task automatic push_beat(input logic [31:0] addr, input logic [63:0] data, input logic [7:0] strb);
    wr_t w;
    for (int p = 0; p < NP; p++) begin
      if (strb[p*4 +: 4] != 4'h0) begin
        w.port = p;
        w.addr = addr + 32'(4 * p);
        w.data = data[p*32 +: 32];
        w.be   = strb[p*4 +: 4];
        exp_q.push_back(w);
      end
    end
  endtask

  task automatic start(input logic [31:0] base, input logic [15:0] trans,
                       input logic [15:0] line, input logic [31:0] stride);
    req_start_i   = 1'b1;
    base_addr_i   = base;
    trans_size_i  = trans;
    line_length_i = line;
    line_stride_i = stride;
    @(posedge clk_i);
    #1;
    req_start_i = 1'b0;
  endtask

  // Present one beat and hold it until accepted; reports how many cycles ready stayed low.
  task automatic send_beat(input logic [63:0] data, input logic [7:0] strb, output int waits);
    bit got;
    stream_valid_i = 1'b1;
    stream_data_i  = data;
    stream_strb_i  = strb;
    waits = 0;
    got   = 1'b0;
    while (!got) begin
      @(negedge clk_i);
      if (stream_ready_o) got = 1'b1;
      else begin
        waits++;
        if (waits >= 50) begin
          check("beat_accept_timeout", 0, 1);
          got = 1'b1;
        end
      end
    end
    @(posedge clk_i);
    #1;
    stream_valid_i = 1'b0;
  endtask

  // Monitor: every port handshake must match the head of the expectation queue.
  initial begin
    wr_t w;
    forever begin
      @(negedge clk_i);
      if (rst_ni) begin
        for (int p = 0; p < NP; p++) begin
          if (tcdm_req_o[p] && tcdm_gnt_i[p]) begin
            if (exp_q.size() == 0) begin
              check("unexpected_write_port", 128'(p) + 128'd100, 128'(p));
            end else begin
              w = exp_q.pop_front();
              check("write_port", 128'(p), 128'(w.port));
              check("write_addr_be_data",
                    {60'd0, tcdm_add_o[p*32 +: 32], tcdm_be_o[p*4 +: 4], tcdm_data_o[p*32 +: 32]},
                    {60'd0, w.addr, w.be, w.data});
              check("write_wen", 128'(tcdm_wen_o[p]), 128'd0);
            end
          end
        end
      end
    end
  end

  initial begin
    int w;
    logic [63:0] d;
    logic [31:0] a1 [4];
    logic [31:0] a2 [4];
    a1 = '{32'h1000, 32'h1008, 32'h1010, 32'h1018};
    a2 = '{32'h1000, 32'h1008, 32'h1100, 32'h1108};

    // Reset state
    repeat (3) @(posedge clk_i);
    #1 rst_ni = 1'b1;
    check("rst_ready_start", 128'(ready_start_o), 1);
    check("rst_stream_ready", 128'(stream_ready_o), 0);
    check("rst_req", 128'(tcdm_req_o), 0);
    check("rst_done", 128'(done_o), 0);
    check("rst_beat_cnt", 128'(beat_cnt_o), 0);
    check("rst_add", 128'(tcdm_add_o), 0);

    // 1D transfer, one beat per cycle
    start(32'h1000, 16'd4, 16'd4, 32'h0);
    check("t1_in_progress", 128'(in_progress_o), 1);
    check("t1_ready_start", 128'(ready_start_o), 0);
    for (int k = 0; k < 4; k++) begin
      d = {32'hB000_0000 + 32'(2*k+1), 32'hA000_0000 + 32'(2*k)};
      push_beat(a1[k], d, 8'hFF);
      send_beat(d, 8'hFF, w);
      check("t1_beat_waits", 128'(w), 0);
    end
    check("t1_done", 128'(done_o), 1);
    check("t1_idle", 128'(ready_start_o), 1);
    check("t1_beat_cnt", 128'(beat_cnt_o), 4);
    @(posedge clk_i); #1;
    check("t1_done_pulse_end", 128'(done_o), 0);

    // 2D transfer: line length 2, stride 0x100
    start(32'h1000, 16'd4, 16'd2, 32'h100);
    for (int k = 0; k < 4; k++) begin
      d = {32'hD000_0000 + 32'(k), 32'hC000_0000 + 32'(k)};
      push_beat(a2[k], d, 8'hFF);
      send_beat(d, 8'hFF, w);
    end
    check("t2_done", 128'(done_o), 1);
    check("t2_beat_cnt", 128'(beat_cnt_o), 4);

    // Skewed grant: port 1 waits three cycles
    start(32'h5000, 16'd1, 16'd1, 32'h0);
    d = 64'h2222_2222_1111_1111;
    push_beat(32'h5000, d, 8'hFF);
    tcdm_gnt_i     = 2'b01;
    stream_valid_i = 1'b1;
    stream_data_i  = d;
    stream_strb_i  = 8'hFF;
    @(negedge clk_i);
    check("t3_req_c1", 128'(tcdm_req_o), 128'b11);
    check("t3_ready_c1", 128'(stream_ready_o), 0);
    @(negedge clk_i);
    check("t3_req_c2", 128'(tcdm_req_o), 128'b10);
    check("t3_ready_c2", 128'(stream_ready_o), 0);
    @(negedge clk_i);
    check("t3_req_c3", 128'(tcdm_req_o), 128'b10);
    check("t3_ready_c3", 128'(stream_ready_o), 0);
    @(posedge clk_i); #1;
    tcdm_gnt_i = 2'b11;
    @(negedge clk_i);
    check("t3_req_c4", 128'(tcdm_req_o), 128'b10);
    check("t3_ready_c4", 128'(stream_ready_o), 1);
    @(posedge clk_i); #1;
    stream_valid_i = 1'b0;
    check("t3_done", 128'(done_o), 1);
    check("t3_beat_cnt", 128'(beat_cnt_o), 1);

    // Partial and all-zero strobes
    start(32'h3000, 16'd2, 16'd2, 32'h0);
    d = 64'h4444_4444_3333_3333;
    push_beat(32'h3000, d, 8'h0F);
    stream_valid_i = 1'b1;
    stream_data_i  = d;
    stream_strb_i  = 8'h0F;
    @(negedge clk_i);
    check("t4_req_partial", 128'(tcdm_req_o), 128'b01);
    check("t4_ready_partial", 128'(stream_ready_o), 1);
    @(posedge clk_i); #1;
    stream_data_i = 64'h5555_5555_6666_6666;
    stream_strb_i = 8'h00;
    @(negedge clk_i);
    check("t4_req_zero", 128'(tcdm_req_o), 0);
    check("t4_ready_zero", 128'(stream_ready_o), 1);
    @(posedge clk_i); #1;
    stream_valid_i = 1'b0;
    check("t4_done", 128'(done_o), 1);
    check("t4_beat_cnt", 128'(beat_cnt_o), 2);

    // Zero-length transfer
    @(posedge clk_i); #1;
    start(32'h7000, 16'd0, 16'd1, 32'h0);
    check("t5_done", 128'(done_o), 1);
    check("t5_ready_start", 128'(ready_start_o), 1);
    check("t5_in_progress", 128'(in_progress_o), 0);
    check("t5_req", 128'(tcdm_req_o), 0);
    @(posedge clk_i); #1;
    check("t5_done_end", 128'(done_o), 0);

    // Clear mid-transfer with requests pending, then restart
    start(32'h4000, 16'd8, 16'd8, 32'h0);
    for (int k = 0; k < 2; k++) begin
      d = {32'hF000_0000 + 32'(k), 32'hE000_0000 + 32'(k)};
      push_beat(32'h4000 + 32'(8*k), d, 8'hFF);
      send_beat(d, 8'hFF, w);
    end
    tcdm_gnt_i     = 2'b00;
    stream_valid_i = 1'b1;
    stream_data_i  = 64'h9999_9999_8888_8888;
    stream_strb_i  = 8'hFF;
    @(negedge clk_i);
    check("t6_req_pending", 128'(tcdm_req_o), 128'b11);
    @(posedge clk_i); #1;
    clear_i = 1'b1;
    @(posedge clk_i); #1;
    clear_i        = 1'b0;
    stream_valid_i = 1'b0;
    tcdm_gnt_i     = 2'b11;
    check("t6_idle", 128'(ready_start_o), 1);
    check("t6_in_progress", 128'(in_progress_o), 0);
    check("t6_req", 128'(tcdm_req_o), 0);
    check("t6_done", 128'(done_o), 0);
    check("t6_beat_cnt", 128'(beat_cnt_o), 0);
    @(posedge clk_i); #1;
    check("t6_no_done", 128'(done_o), 0);
    start(32'h2000, 16'd1, 16'd1, 32'h0);
    d = 64'h7777_7777_6666_6666;
    push_beat(32'h2000, d, 8'hFF);
    send_beat(d, 8'hFF, w);
    check("t6_restart_done", 128'(done_o), 1);

    repeat (2) @(posedge clk_i);
    check("scoreboard_drained", 128'(exp_q.size()), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  // Global watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
